// File: rtl/dec_nx2n_pipe.sv
// dec_nx2n_pipe: registered N-to-2^N one-hot decoder with valid/ready handshakes.
// A single output register holds the decoded strobe until downstream takes it.
// An optional self-test sweep walks every select code 0..OUT_W-1 in order.
// It is compiled in only when the macro DEC_SWEEP_EN is defined. Without that
// macro, sweep_start is ignored and sweep_busy is tied low.
module dec_nx2n_pipe #(
   parameter int SEL_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   in_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [(1<<SEL_W)-1:0] out_onehot,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               sweep_start,
   output logic               sweep_busy
);

   localparam int OUT_W = 1 << SEL_W;

   logic             free;         // output register can take a new code this cycle
   logic             sweep_load;   // sweep counter is loaded into the output register
   logic [SEL_W-1:0] cnt;          // next sweep code
   logic             load;
   logic [SEL_W-1:0] load_sel;
   logic [OUT_W-1:0] load_onehot;

   assign free = !out_valid || out_ready;

`ifdef DEC_SWEEP_EN
   typedef enum logic {IDLE, SWEEP} state_t;

   state_t state;

   assign sweep_busy = (state == SWEEP);
   // A sweep_start seen in IDLE wins over in_valid, so the input is refused that cycle.
   assign in_ready   = free && (state == IDLE) && !sweep_start;
   assign sweep_load = sweep_busy && free;

   // Sweep FSM: walk the counter through every code, advancing only when a code is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (state == IDLE) begin
         if (sweep_start)
            state <= SWEEP;
      end else if (free) begin
         cnt <= cnt + SEL_W'(1);
         if (cnt == {SEL_W{1'b1}})
            state <= IDLE;
      end
   end
`else
   logic unused_sweep_start;

   assign unused_sweep_start = sweep_start;
   assign sweep_busy         = 1'b0;
   assign in_ready           = free;
   assign sweep_load         = 1'b0;
   assign cnt                = '0;
`endif

   // Pick the code to load (sweep counter or accepted input) and decode it.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path
      // leaves it unassigned; an unassigned path would infer a latch.
      load        = sweep_load || (in_valid && in_ready);
      load_sel    = sweep_load ? cnt : in_sel;
      load_onehot = '0;
      if (en)
         load_onehot[load_sel] = 1'b1;
   end

   // Output register: load a new code, hold under backpressure, or drain to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples
      // pre-edge values; blocking assignments here would create order-dependent races.
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_onehot <= '0;
         out_sel    <= '0;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_onehot <= load_onehot;
         out_sel    <= load_sel;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
         out_onehot <= '0;
      end
   end

endmodule

// File: tb/tb_dec_nx2n_pipe.sv
// tb_dec_nx2n_pipe: directed bench for dec_nx2n_pipe (SEL_W=3).
// A transaction-level model uses a queue of pending sweep codes and a single
// expected output slot. It is checked on every falling edge. Literal expectations
// at key points pin the model. Define DEC_SWEEP_EN to exercise the sweep mode.
module tb_dec_nx2n_pipe;

   localparam int SEL_W = 3;
   localparam int OUT_W = 1 << SEL_W;
`ifdef DEC_SWEEP_EN
   localparam bit SWEEP_ON = 1'b1;
`else
   localparam bit SWEEP_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] in_sel;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;
   logic [SEL_W-1:0] out_sel;
   logic             sweep_start;
   logic             sweep_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] oh_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   dec_nx2n_pipe #(.SEL_W(SEL_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sel      (in_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_onehot  (out_onehot),
      .out_sel     (out_sel),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit               m_valid = 1'b0;
   logic [OUT_W-1:0] m_oh    = '0;
   int               m_sel   = 0;
   int               m_q[$];          // sweep codes still to be emitted
   bit               m_free;
   bit               m_take;
   int               m_code;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_oh    = '0;
         m_sel   = 0;
         m_q.delete();
      end else begin
         m_free = !m_valid || out_ready;
         m_take = 1'b0;
         m_code = 0;
         if (m_q.size() != 0) begin
            if (m_free) begin
               m_code = m_q.pop_front();
               m_take = 1'b1;
            end
         end else if (SWEEP_ON && sweep_start) begin
            for (int i = 0; i < OUT_W; i++) m_q.push_back(i);
         end else if (in_valid && m_free) begin
            m_code = int'(in_sel);
            m_take = 1'b1;
         end
         if (m_take) begin
            m_valid = 1'b1;
            m_sel   = m_code;
            m_oh    = en ? (OUT_W'(1) << m_code) : '0;
         end else if (out_ready) begin
            m_valid = 1'b0;
            m_oh    = '0;
         end
      end
   end

   // Compare process: DUT against model on every falling edge.
   always @(negedge clk) begin
      check("cmp_valid", 32'(out_valid), 32'(m_valid));
      check("cmp_onehot", 32'(out_onehot), 32'(m_oh));
      if (m_valid)
         check("cmp_sel", 32'(out_sel), 32'(m_sel));
      check("cmp_busy", 32'(sweep_busy), 32'(m_q.size() != 0));
      check("cmp_in_ready", 32'(in_ready),
            32'((!m_valid || out_ready) && (m_q.size() == 0) && !(SWEEP_ON && sweep_start)));
      check("cmp_at_most_one_bit", 32'($countones(out_onehot) <= 1), 32'(1));
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic e,
                        input logic r, input logic ss);
      in_valid    = v;
      in_sel      = s;
      en          = e;
      out_ready   = r;
      sweep_start = ss;
   endtask

   // Advance past one rising edge; returns 1 time unit after the next falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   int got[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // 1 Reset with in_valid high.
      rst_n = 1'b0;
      drive(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_onehot", 32'(out_onehot), 32'h00);
      check("rst_busy", 32'(sweep_busy), 32'h0);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'h1);
      tick();

      // 2 Stream 0..7 at full rate.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
         tick();
         check("stream_valid", 32'(out_valid), 32'h1);
         check("stream_onehot", 32'(out_onehot), 32'(oh_tbl[i]));
      end
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      check("stream_drain", 32'(out_valid), 32'h0);

      // 3 Backpressure.
      drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
      tick();
      check("bp_first", 32'(out_onehot), 32'h20);
      drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
      #1;
      check("bp_in_ready_low", 32'(in_ready), 32'h0);
      tick();
      check("bp_hold1", 32'(out_onehot), 32'h20);
      check("bp_hold_sel", 32'(out_sel), 32'h5);
      tick();
      check("bp_hold2", 32'(out_onehot), 32'h20);
      drive(1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
      #1;
      check("bp_in_ready_high", 32'(in_ready), 32'h1);
      tick();
      check("bp_next", 32'(out_onehot), 32'h04);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      check("bp_drain_valid", 32'(out_valid), 32'h0);
      check("bp_drain_onehot", 32'(out_onehot), 32'h00);

      // 4 Enable low.
      drive(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
      tick();
      check("en0_valid", 32'(out_valid), 32'h1);
      check("en0_onehot", 32'(out_onehot), 32'h00);
      check("en0_sel", 32'(out_sel), 32'h6);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();

      // Reset while a transfer is held under backpressure.
      drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      tick();
      check("hold_before_rst", 32'(out_onehot), 32'h02);
      drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'h0);
      check("rst_mid_onehot", 32'(out_onehot), 32'h00);
      tick();
      rst_n = 1'b1;
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();

`ifdef DEC_SWEEP_EN
      // 5a Sweep with out_ready held high; in_valid stays high.
      drive(1'b1, 3'd4, 1'b1, 1'b1, 1'b1);
      #1;
      check("sw_start_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("sw_busy_first", 32'(sweep_busy), 32'h1);
      check("sw_no_take", 32'(out_valid), 32'h0);
      drive(1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("sw_onehot", 32'(out_onehot), 32'(oh_tbl[k]));
         check("sw_busy", 32'(sweep_busy), 32'(k < 7));
         check("sw_in_ready", 32'(in_ready), 32'(k == 7));
      end
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      check("sw_after_sel", 32'(out_sel), 32'h4);
      tick();
      check("sw_drained", 32'(out_valid), 32'h0);

      // 5b Sweep with out_ready toggling: record every handshake.
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      tick();
      got.delete();
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 3'd0, 1'b1, 1'((i % 2) == 0), 1'b0);
         #1;
         if (out_valid && out_ready) got.push_back(int'(out_sel));
         tick();
         if (!sweep_busy && !out_valid) break;
      end
      check("sw_bp_count", 32'(got.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < got.size())
            check("sw_bp_code", 32'(got[k]), 32'(k));
      end
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();

      // 6 Reset mid-sweep after code 3 is output, then restart.
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      check("sw_rst_code3", 32'(out_onehot), 32'h08);
      rst_n = 1'b0;
      #1;
      check("sw_rst_valid", 32'(out_valid), 32'h0);
      check("sw_rst_busy", 32'(sweep_busy), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      check("sw_restart", 32'(out_onehot), 32'h01);
      for (int k = 0; k < 9; k++) tick();
      check("sw_restart_done", 32'(sweep_busy), 32'h0);
`else
      // sweep_start must be ignored: the input is taken and no sweep begins.
      drive(1'b1, 3'd4, 1'b1, 1'b1, 1'b1);
      #1;
      check("nosw_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("nosw_onehot", 32'(out_onehot), 32'h10);
      check("nosw_busy", 32'(sweep_busy), 32'h0);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      tick();
      check("nosw_drain", 32'(out_valid), 32'h0);
      check("nosw_busy2", 32'(sweep_busy), 32'h0);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
